// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Fetch-side branch direction/target predictor. A direct-mapped BTB with one
// 2-bit saturating counter per entry is looked up from the fetch PC (result
// registered, one-cycle latency) and trained by resolved conditional branches
// reported from the execute stage.
//
// Parameters:
//   IDX_BITS  table index width, 2**IDX_BITS entries
//   XLEN      PC / target width
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   lu_valid       fetch presents lu_pc for prediction this cycle
//   lu_pc          fetch PC (bits [1:0] ignored)
//   lu_stall       fetch stalled: prediction outputs hold
//   pred_valid     registered: prediction for the PC sampled last cycle
//   pred_hit       registered: BTB entry valid and tag matched
//   pred_taken     registered: predicted taken
//   pred_target    registered: predicted next PC
//   upd_valid      execute reports a resolved conditional branch
//   upd_pc         PC of the resolved branch
//   upd_taken      resolved direction
//   upd_target     resolved taken target
//
// Configuration macro:
//   BP_BYPASS_EN   when defined, a same-cycle update to the looked-up index
//                  is forwarded into the lookup; otherwise the lookup reads
//                  the pre-update entry.
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lu_valid,
    input  logic [XLEN-1:0] lu_pc,
    input  logic            lu_stall,
    output logic            pred_valid,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic [ENTRIES-1:0] valid_arr;
    logic [TAG_W-1:0]   tag_arr    [ENTRIES];
    logic [XLEN-1:0]    target_arr [ENTRIES];
    logic [1:0]         ctr_arr    [ENTRIES];

    logic [IDX_BITS-1:0] lu_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]    lu_tag;
    logic [TAG_W-1:0]    upd_tag;

    // PC byte-offset bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lu_pc[1:0], upd_pc[1:0]};

    assign lu_idx  = lu_pc[IDX_BITS+1:2];
    assign lu_tag  = lu_pc[XLEN-1:IDX_BITS+2];
    assign upd_idx = upd_pc[IDX_BITS+1:2];
    assign upd_tag = upd_pc[XLEN-1:IDX_BITS+2];

    // Post-update contents of the entry addressed by the update port.
    // A miss that resolved not-taken never allocates, so it writes nothing.
    logic            upd_hit;
    logic            wr_en;
    logic [1:0]      new_ctr;
    logic [XLEN-1:0] new_target;

    always_comb begin
        upd_hit    = valid_arr[upd_idx] && (tag_arr[upd_idx] == upd_tag);
        wr_en      = 1'b0;
        new_ctr    = ctr_arr[upd_idx];
        new_target = target_arr[upd_idx];
        if (upd_valid) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (upd_taken) begin
                    new_ctr    = (ctr_arr[upd_idx] == 2'b11) ? 2'b11 : ctr_arr[upd_idx] + 2'b01;
                    new_target = upd_target;
                end else begin
                    new_ctr    = (ctr_arr[upd_idx] == 2'b00) ? 2'b00 : ctr_arr[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                wr_en      = 1'b1;
                new_ctr    = 2'b10;
                new_target = upd_target;
            end
        end
    end

    // Entry seen by the lookup port.
    logic            rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [XLEN-1:0] rd_target;
    logic [1:0]      rd_ctr;

    always_comb begin
        rd_valid  = valid_arr[lu_idx];
        rd_tag    = tag_arr[lu_idx];
        rd_target = target_arr[lu_idx];
        rd_ctr    = ctr_arr[lu_idx];
`ifdef BP_BYPASS_EN
        // Forward the in-flight write so the lookup behaves as if the update
        // had landed a cycle earlier.
        if (wr_en && (upd_idx == lu_idx)) begin
            rd_valid  = 1'b1;
            rd_tag    = upd_tag;
            rd_target = new_target;
            rd_ctr    = new_ctr;
        end
`endif
    end

    logic            lu_hit;
    logic            lu_taken;
    logic [XLEN-1:0] lu_next;

    assign lu_hit   = rd_valid && (rd_tag == lu_tag);
    assign lu_taken = lu_hit && rd_ctr[1];
    assign lu_next  = lu_taken ? rd_target : lu_pc + XLEN'(4);

    // Valid bits and counters are the only reset table state; a write in a
    // reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_arr <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_arr[i] <= 2'b01;
            end
        end else if (wr_en) begin
            valid_arr[upd_idx] <= 1'b1;
            ctr_arr[upd_idx]   <= new_ctr;
        end
    end

    // Tag and target storage carries no reset; stale contents are masked by valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_arr[upd_idx]    <= upd_tag;
            target_arr[upd_idx] <= new_target;
        end
    end

    // Prediction registers: hold while stalled, clear when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_valid  <= 1'b0;
            pred_hit    <= 1'b0;
            pred_taken  <= 1'b0;
            pred_target <= '0;
        end else if (!lu_stall) begin
            if (lu_valid) begin
                pred_valid  <= 1'b1;
                pred_hit    <= lu_hit;
                pred_taken  <= lu_taken;
                pred_target <= lu_next;
            end else begin
                pred_valid  <= 1'b0;
                pred_hit    <= 1'b0;
                pred_taken  <= 1'b0;
                pred_target <= '0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed bench for branch_predictor (IDX_BITS=6, XLEN=32). Each step drives
// one cycle of lookup/update/reset inputs and pushes the prediction expected
// one cycle later onto a scoreboard queue; after the edge the entry is popped
// and compared against the registered outputs. Define BP_BYPASS_EN for both
// the bench and the design to select the forwarding expectations.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

    typedef struct packed {
        logic        v;
        logic        h;
        logic        t;
        logic [31:0] tg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        lu_valid;
    logic [31:0] lu_pc;
    logic        lu_stall;
    logic        pred_valid;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    exp_t  sb_q[$];
    string name_q[$];
    int    total = 0;
    int    bad   = 0;

    branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .lu_valid    (lu_valid),
        .lu_pc       (lu_pc),
        .lu_stall    (lu_stall),
        .pred_valid  (pred_valid),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Pop one expected prediction and compare it to the registered outputs.
    task automatic checkOutput();
        exp_t  e;
        string nm;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty got=none exp=entry");
            return;
        end
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        assert (pred_valid === e.v) else begin
            bad++;
            $error("[TB] FAIL %s.valid got=%0b exp=%0b", nm, pred_valid, e.v);
        end
        total++;
        assert (pred_hit === e.h) else begin
            bad++;
            $error("[TB] FAIL %s.hit got=%0b exp=%0b", nm, pred_hit, e.h);
        end
        total++;
        assert (pred_taken === e.t) else begin
            bad++;
            $error("[TB] FAIL %s.taken got=%0b exp=%0b", nm, pred_taken, e.t);
        end
        total++;
        assert (pred_target === e.tg) else begin
            bad++;
            $error("[TB] FAIL %s.target got=%h exp=%h", nm, pred_target, e.tg);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, clock, then check.
    task automatic applyStimulus(
        input string       nm,
        input logic        r,
        input logic        lv,
        input logic [31:0] lpc,
        input logic        st,
        input logic        uv,
        input logic [31:0] upc,
        input logic        ut,
        input logic [31:0] utg,
        input logic        ev,
        input logic        eh,
        input logic        et,
        input logic [31:0] etg
    );
        exp_t e;
        rst        = r;
        lu_valid   = lv;
        lu_pc      = lpc;
        lu_stall   = st;
        upd_valid  = uv;
        upd_pc     = upc;
        upd_taken  = ut;
        upd_target = utg;
        e.v  = ev;
        e.h  = eh;
        e.t  = et;
        e.tg = etg;
        sb_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic lookup(input string nm, input logic [31:0] pc,
                          input logic eh, input logic et, input logic [31:0] etg);
        applyStimulus(nm, 1'b0, 1'b1, pc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, eh, et, etg);
    endtask

    task automatic update(input string nm, input logic [31:0] pc,
                          input logic tk, input logic [31:0] tg);
        applyStimulus(nm, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, pc, tk, tg, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b1; lu_valid = 1'b0; lu_pc = '0; lu_stall = 1'b0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        @(posedge clk);
        #1;

        // Reset: lookup and update presented during reset are discarded.
        applyStimulus("reset", 1'b1, 1'b1, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h40,
                      1'b0, 1'b0, 1'b0, 32'h0);

        // Cold lookup misses and predicts pc+4.
        lookup("cold_miss", 32'h100, 1'b0, 1'b0, 32'h104);

        // Taken update allocates with weak-taken.
        update("alloc", 32'h100, 1'b1, 32'h40);
        lookup("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h40);

        // Not-taken training down to strong-NT and saturation at 00.
        update("nt1", 32'h100, 1'b0, 32'h0);
        lookup("ctr01", 32'h100, 1'b1, 1'b0, 32'h104);
        update("nt2", 32'h100, 1'b0, 32'h0);
        lookup("ctr00", 32'h100, 1'b1, 1'b0, 32'h104);
        update("nt3", 32'h100, 1'b0, 32'h0);
        update("t_from00", 32'h100, 1'b1, 32'h48);
        lookup("sat_low", 32'h100, 1'b1, 1'b0, 32'h104);

        // Taken training up to strong-T, saturation at 11, target refresh.
        update("t_to10", 32'h100, 1'b1, 32'h48);
        lookup("ctr10", 32'h100, 1'b1, 1'b1, 32'h48);
        update("t_to11", 32'h100, 1'b1, 32'h48);
        update("t_sat11", 32'h100, 1'b1, 32'h48);
        update("nt_to10", 32'h100, 1'b0, 32'h0);
        lookup("sat_high", 32'h100, 1'b1, 1'b1, 32'h48);

        // Aliasing on index 0: 0x200 evicts 0x100.
        update("alias_upd", 32'h200, 1'b1, 32'h80);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h80);

        // Not-taken miss on the same index never allocates or disturbs.
        update("nt_miss", 32'h500, 1'b0, 32'h0);
        lookup("nt_miss_lu", 32'h500, 1'b0, 1'b0, 32'h504);
        lookup("nt_keep", 32'h200, 1'b1, 1'b1, 32'h80);

        // Stall holds the previous prediction; updates still land.
        applyStimulus("stall1", 1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                      1'b1, 1'b1, 1'b1, 32'h80);
        applyStimulus("stall2", 1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 32'h604, 1'b1, 32'h20,
                      1'b1, 1'b1, 1'b1, 32'h80);
        applyStimulus("stall3", 1'b0, 1'b0, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,
                      1'b1, 1'b1, 1'b1, 32'h80);
        lookup("unstall", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("stall_upd", 32'h604, 1'b1, 1'b1, 32'h20);

        // Idle cycle clears the prediction.
        applyStimulus("idle", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,
                      1'b0, 1'b0, 1'b0, 32'h0);

        // pc+4 wraps at the top of the address space.
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Same-cycle update and lookup to the same index.
`ifdef BP_BYPASS_EN
        applyStimulus("same_cycle", 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 1'b1, 32'h10,
                      1'b1, 1'b1, 1'b1, 32'h10);
`else
        applyStimulus("same_cycle", 1'b0, 1'b1, 32'h300, 1'b0, 1'b1, 32'h300, 1'b1, 32'h10,
                      1'b1, 1'b0, 1'b0, 32'h304);
`endif
        lookup("after_same", 32'h300, 1'b1, 1'b1, 32'h10);

        // Reset mid-stream invalidates everything; concurrent update dropped.
        applyStimulus("mid_reset", 1'b1, 1'b1, 32'h300, 1'b0, 1'b1, 32'h704, 1'b1, 32'h99,
                      1'b0, 1'b0, 1'b0, 32'h0);
        lookup("post_rst", 32'h300, 1'b0, 1'b0, 32'h304);
        lookup("rst_drop", 32'h704, 1'b0, 1'b0, 32'h708);
        lookup("rst_604", 32'h604, 1'b0, 1'b0, 32'h608);

        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
